// File: rtl/game_round_sequencer_pkg.sv
// Shared definitions for the memory-game round sequencer: FSM states,
// win pattern, LFSR taps and symbol helpers.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_GAP,
        ST_PLAY,
        ST_HOLD,
        ST_END
    } state_t;

    localparam logic [3:0] WIN_PATTERN = 4'b1111;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [3:0] sym_onehot(input logic [1:0] sym);
        return 4'b0001 << sym;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic is_onehot(input logic [3:0] k);
        return (k != '0) && ((k & (k - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/game_round_sequencer_player_tracker.sv
// Per-player progress tracker: matches one-hot key strobes against the
// 4-step pattern; a wrong symbol restarts the player from step 0.
module player_tracker
    import game_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [3:0] key,
    input  logic [7:0] pattern,
    output logic [3:0] progress,
    output logic       done
);

    logic [1:0] ptr;
    logic [3:0] want;

    assign want = sym_onehot(pattern[{ptr, 1'b0} +: 2]);
    assign done = (progress == WIN_PATTERN);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            progress <= '0;
            ptr      <= '0;
        end else if (clear) begin
            progress <= '0;
            ptr      <= '0;
        end else if (enable && !done && is_onehot(key)) begin
            if (key == want) begin
                progress[ptr] <= 1'b1;
                ptr           <= ptr + 2'd1;
            end else begin
                progress <= '0;
                ptr      <= '0;
            end
        end
    end

endmodule

// File: rtl/game_round_sequencer.sv
// Round controller: draws a pattern from the LFSR, flashes it on Show,
// runs the timed play window and holds Start/A/B for the winner checker.
module game_round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned STEP_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES   = 12_500_000,
    parameter int unsigned ROUND_CYCLES = 500_000_000,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter logic [7:0]  SEED         = 8'hA5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Go,
    input  logic [3:0] KeyA,
    input  logic [3:0] KeyB,
    output logic [3:0] Show,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       Start,
    output logic       Busy,
    output logic       Timeout
);

    state_t      state;
    logic [7:0]  lfsr;
    logic [7:0]  pattern;
    logic [1:0]  step;
    logic [1:0]  step_nx;
    logic [31:0] cnt;
    logic [31:0] timer;
    logic        a_done;
    logic        b_done;
    logic        a_last;
    logic        b_last;
    logic        trk_en;
    logic        trk_clr;

    assign step_nx = step + 2'd1;
    assign trk_en  = (state == ST_PLAY);
    assign trk_clr = (state == ST_LOAD) || (state == ST_END);

    // A player is finishing on this edge when only the last step remains
    // and the last symbol is struck; used to suppress Timeout on expiry.
    assign a_last = (A == 4'b0111) && (KeyA == sym_onehot(pattern[7:6]));
    assign b_last = (B == 4'b0111) && (KeyB == sym_onehot(pattern[7:6]));

    player_tracker u_track_a (
        .Clk      (Clk),
        .Rst      (Rst),
        .enable   (trk_en),
        .clear    (trk_clr),
        .key      (KeyA),
        .pattern  (pattern),
        .progress (A),
        .done     (a_done)
    );

    player_tracker u_track_b (
        .Clk      (Clk),
        .Rst      (Rst),
        .enable   (trk_en),
        .clear    (trk_clr),
        .key      (KeyB),
        .pattern  (pattern),
        .progress (B),
        .done     (b_done)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= ST_IDLE;
            lfsr    <= SEED;
            pattern <= '0;
            step    <= '0;
            cnt     <= '0;
            timer   <= '0;
            Show    <= '0;
            Start   <= 1'b0;
            Busy    <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            lfsr    <= lfsr_next(lfsr);
            Timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Go) begin
                        // Capture the Go-cycle LFSR value now so LOAD sees it
                        pattern <= lfsr;
                        Busy    <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    step  <= '0;
                    cnt   <= STEP_CYCLES - 1;
                    Show  <= sym_onehot(pattern[1:0]);
                    state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt == '0) begin
                        Show  <= '0;
                        cnt   <= GAP_CYCLES - 1;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 32'd1;
                    end else if (step != 2'd3) begin
                        step  <= step_nx;
                        Show  <= sym_onehot(pattern[{step_nx, 1'b0} +: 2]);
                        cnt   <= STEP_CYCLES - 1;
                        state <= ST_SHOW;
                    end else begin
                        timer <= ROUND_CYCLES - 1;
                        Start <= 1'b1;
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (a_done || b_done) begin
                        cnt   <= HOLD_CYCLES - 1;
                        state <= ST_HOLD;
                    end else if (timer == '0) begin
                        cnt     <= HOLD_CYCLES - 1;
                        Timeout <= !(a_last || b_last);
                        state   <= ST_HOLD;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        Start <= 1'b0;
                        state <= ST_END;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_END: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Show  <= '0;
                    Start <= 1'b0;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
